// File: rtl/usb_rx_packet_collector_if.sv
// Bit-stream and parallel-field bundle for the USB receive packet collector.
//   Upstream side (master): sop, eop, bit_valid, bit_in.
//   Collector side (slave):  pid_raw, data_raw, crc16_raw, pkt_ready,
//                            pkt_is_data, pid_err, rx_error, busy.
// DATA_BITS must match the collector's DATA_BITS.
interface usb_rx_packet_collector_if #(
  parameter int DATA_BITS = 64
);
  logic                 sop;
  logic                 eop;
  logic                 bit_valid;
  logic                 bit_in;
  logic [7:0]           pid_raw;
  logic [DATA_BITS-1:0] data_raw;
  logic [15:0]          crc16_raw;
  logic                 pkt_ready;
  logic                 pkt_is_data;
  logic                 pid_err;
  logic                 rx_error;
  logic                 busy;

  modport master (
    output sop, eop, bit_valid, bit_in,
    input  pid_raw, data_raw, crc16_raw, pkt_ready, pkt_is_data,
           pid_err, rx_error, busy
  );

  modport slave (
    input  sop, eop, bit_valid, bit_in,
    output pid_raw, data_raw, crc16_raw, pkt_ready, pkt_is_data,
           pid_err, rx_error, busy
  );
endinterface

// File: rtl/usb_rx_packet_collector.sv
// Serial-to-parallel USB receive packet collector.
// Shifts the decoded, unstuffed bit stream between SOP and EOP into PID,
// payload and CRC16 registers in raw wire order (first bit -> field MSB),
// judges the packet length at EOP and presents the fields with a one-cycle
// pkt_ready strobe, or pulses rx_error on a bad length or an aborted packet.
// Ports:
//   clk  - system clock
//   rst  - synchronous active-high reset
//   bus  - slave side of usb_rx_packet_collector_if (bit stream in,
//          collected fields and status out)
module usb_rx_packet_collector #(
  parameter int DATA_BITS = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  usb_rx_packet_collector_if.slave bus
);

  localparam int         TOTAL_BITS = 8 + DATA_BITS + 16;
  localparam logic [6:0] CNT_PID    = 7'd8;
  localparam logic [6:0] PID_LAST   = 7'd7;
  localparam logic [6:0] DATA_LAST  = 7'(8 + DATA_BITS - 1);
  localparam logic [6:0] CNT_FULL   = 7'(TOTAL_BITS);
  localparam logic [6:0] CNT_MAX    = 7'd127;

  typedef enum logic [2:0] {IDLE, PID, DATA, CRC, OVERFLOW} state_t;

  state_t               state;
  logic [6:0]           cnt;
  logic [7:0]           pid_sr;
  logic [DATA_BITS-1:0] data_sr;
  logic [15:0]          crc_sr;

  logic [7:0]           pid_q;
  logic [DATA_BITS-1:0] data_q;
  logic [15:0]          crc_q;
  logic                 pkt_ready_q;
  logic                 pkt_is_data_q;
  logic                 pid_err_q;
  logic                 rx_error_q;

  // Shift registers and count after this cycle's bit, so that a bit_valid
  // coincident with eop is included before the length is judged.
  logic [7:0]           pid_nx;
  logic [DATA_BITS-1:0] data_nx;
  logic [15:0]          crc_nx;
  logic [6:0]           cnt_nx;
  logic                 pid_err_nx;

  // NOTE: every signal gets a default at the top of the block so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pid_nx  = pid_sr;
    data_nx = data_sr;
    crc_nx  = crc_sr;
    cnt_nx  = cnt;
    if (bus.bit_valid && state != IDLE) begin
      unique case (state)
        PID:  pid_nx  = {pid_sr[6:0], bus.bit_in};
        DATA: data_nx = {data_sr[DATA_BITS-2:0], bus.bit_in};
        // Once all 16 CRC bits are in, further bits are overflow, not CRC.
        CRC:  if (cnt < CNT_FULL) crc_nx = {crc_sr[14:0], bus.bit_in};
        default: ;
      endcase
      if (cnt != CNT_MAX) cnt_nx = cnt + 7'd1;
    end
    pid_err_nx = (pid_nx[7:4] != ~pid_nx[3:0]);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  // NOTE: the shift registers carry no storage-array semantics, so they are
  // reset together with the control state; the whole block clears in one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      pid_sr        <= '0;
      data_sr       <= '0;
      crc_sr        <= '0;
      pid_q         <= '0;
      data_q        <= '0;
      crc_q         <= '0;
      pkt_ready_q   <= 1'b0;
      pkt_is_data_q <= 1'b0;
      pid_err_q     <= 1'b0;
      rx_error_q    <= 1'b0;
    end else begin
      pkt_ready_q <= 1'b0;
      rx_error_q  <= 1'b0;

      if (bus.sop) begin
        // A sop mid-packet abandons it; sop also outranks a same-cycle eop.
        if (state != IDLE) rx_error_q <= 1'b1;
        state   <= PID;
        cnt     <= '0;
        pid_sr  <= '0;
        data_sr <= '0;
        crc_sr  <= '0;
      end else if (state != IDLE) begin
        pid_sr  <= pid_nx;
        data_sr <= data_nx;
        crc_sr  <= crc_nx;
        cnt     <= cnt_nx;

        if (bus.eop) begin
          state <= IDLE;
          if (cnt_nx == CNT_PID) begin
            // Handshake: payload and CRC outputs keep their previous values.
            pkt_ready_q   <= 1'b1;
            pkt_is_data_q <= 1'b0;
            pid_q         <= pid_nx;
            pid_err_q     <= pid_err_nx;
          end else if (cnt_nx == CNT_FULL) begin
            pkt_ready_q   <= 1'b1;
            pkt_is_data_q <= 1'b1;
            pid_q         <= pid_nx;
            data_q        <= data_nx;
            crc_q         <= crc_nx;
            pid_err_q     <= pid_err_nx;
          end else begin
            rx_error_q <= 1'b1;
          end
        end else if (bus.bit_valid) begin
          unique case (state)
            PID:  if (cnt == PID_LAST)  state <= DATA;
            DATA: if (cnt == DATA_LAST) state <= CRC;
            CRC:  if (cnt == CNT_FULL)  state <= OVERFLOW;
            default: ;
          endcase
        end
      end
    end
  end

  assign bus.pid_raw     = pid_q;
  assign bus.data_raw    = data_q;
  assign bus.crc16_raw   = crc_q;
  assign bus.pkt_ready   = pkt_ready_q;
  assign bus.pkt_is_data = pkt_is_data_q;
  assign bus.pid_err     = pid_err_q;
  assign bus.rx_error    = rx_error_q;
  assign bus.busy        = (state != IDLE);

endmodule

// File: tb/tb_usb_rx_packet_collector.sv
// Self-checking bench for usb_rx_packet_collector (DATA_BITS = 64).
// A reference model tracks the bits received since sop in a queue and judges
// each packet by its length at eop; directed steps follow the test plan and a
// randomized phase mixes valid, short, long and aborted packets.
module tb_usb_rx_packet_collector;

  localparam int DB = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  usb_rx_packet_collector_if #(.DATA_BITS(DB)) bus ();

  usb_rx_packet_collector #(.DATA_BITS(DB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit            m_active;
  bit            rxq[$];
  logic [7:0]    m_pid;
  logic [DB-1:0] m_data;
  logic [15:0]   m_crc;
  logic          m_is_data;
  logic          m_pid_err;
  logic          e_ready;
  logic          e_err;

  bit            tx_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Judge a finished packet purely from how many bits arrived.
  task automatic model_eop();
    if (rxq.size() == 8 || rxq.size() == 8 + DB + 16) begin
      e_ready = 1'b1;
      for (int i = 0; i < 8; i++) m_pid[7-i] = rxq[i];
      m_pid_err = (m_pid[7:4] != ~m_pid[3:0]);
      m_is_data = (rxq.size() != 8);
      if (m_is_data) begin
        for (int i = 0; i < DB; i++) m_data[DB-1-i] = rxq[8+i];
        for (int i = 0; i < 16; i++) m_crc[15-i] = rxq[8+DB+i];
      end
    end else begin
      e_err = 1'b1;
    end
  endtask

  task automatic model_step(input bit s, input bit e, input bit v, input bit b);
    e_ready = 1'b0;
    e_err   = 1'b0;
    if (s) begin
      if (m_active) e_err = 1'b1;
      m_active = 1'b1;
      rxq.delete();
    end else if (m_active) begin
      if (v) rxq.push_back(b);
      if (e) begin
        m_active = 1'b0;
        model_eop();
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_pkt_ready"}, 64'(bus.pkt_ready), 64'(e_ready));
    chk({tag, "_rx_error"},  64'(bus.rx_error),  64'(e_err));
    chk({tag, "_busy"},      64'(bus.busy),      64'(m_active));
    chk({tag, "_pid_raw"},   64'(bus.pid_raw),   64'(m_pid));
    chk({tag, "_data_raw"},  64'(bus.data_raw),  64'(m_data));
    chk({tag, "_crc16_raw"}, 64'(bus.crc16_raw), 64'(m_crc));
    chk({tag, "_pid_err"},   64'(bus.pid_err),   64'(m_pid_err));
    if (e_ready) chk({tag, "_pkt_is_data"}, 64'(bus.pkt_is_data), 64'(m_is_data));
  endtask

  // One clock cycle: inputs set at the falling edge, outputs checked 1 time
  // unit after the rising edge that sampled them.
  task automatic drive(input string tag, input bit s, input bit e, input bit v, input bit b);
    @(negedge clk);
    bus.sop       = s;
    bus.eop       = e;
    bus.bit_valid = v;
    bus.bit_in    = b;
    model_step(s, e, v, b);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  // Reset asserted with a live bit to confirm it overrides the stream.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst           = 1'b1;
    bus.sop       = 1'b0;
    bus.eop       = 1'b0;
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    m_active  = 1'b0;
    rxq.delete();
    m_pid     = '0;
    m_data    = '0;
    m_crc     = '0;
    m_is_data = 1'b0;
    m_pid_err = 1'b0;
    e_ready   = 1'b0;
    e_err     = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_is_data"}, 64'(bus.pkt_is_data), 64'(0));
    check_outputs(tag);
    @(negedge clk);
    rst           = 1'b0;
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
  endtask

  // Send tx_q after a sop. eop_mode: 0 separate eop, 1 eop with last bit,
  // 2 no eop (packet left open). Random idle gaps up to max_gap cycles.
  task automatic send_pkt(input string tag, input int eop_mode, input int max_gap);
    int n;
    n = tx_q.size();
    drive({tag, "_sop"}, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < n; i++) begin
      int g;
      g = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int k = 0; k < g; k++) drive({tag, "_gap"}, 1'b0, 1'b0, 1'b0, 1'b0);
      drive({tag, "_bit"}, 1'b0, (eop_mode == 1 && i == n - 1), 1'b1, tx_q[i]);
    end
    if (eop_mode == 0 || (eop_mode == 1 && n == 0))
      drive({tag, "_eop"}, 1'b0, 1'b1, 1'b0, 1'b0);
    if (eop_mode != 2) drive({tag, "_after"}, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic push_lsb_first(input logic [7:0] v);
    for (int i = 0; i < 8; i++) tx_q.push_back(v[i]);
  endtask

  task automatic push_random(input int n);
    for (int i = 0; i < n; i++) tx_q.push_back(bit'($urandom_range(0, 1)));
  endtask

  initial begin
    bus.sop = 1'b0; bus.eop = 1'b0; bus.bit_valid = 1'b0; bus.bit_in = 1'b0;
    m_active = 1'b0;

    // Reset state.
    do_reset("reset");
    drive("idle", 1'b0, 1'b0, 1'b0, 1'b0);

    // DATA0 packet: PID 0xC3 LSB-first, payload 1 then zeros, CRC 8 ones then 8 zeros.
    tx_q.delete();
    push_lsb_first(8'hC3);
    tx_q.push_back(1'b1);
    for (int i = 1; i < DB; i++) tx_q.push_back(1'b0);
    for (int i = 0; i < 16; i++) tx_q.push_back(i < 8);
    send_pkt("data0", 0, 0);
    chk("data0_pid_const",  64'(bus.pid_raw),   64'h00C3);
    chk("data0_data_const", 64'(bus.data_raw),  64'h8000_0000_0000_0000);
    chk("data0_crc_const",  64'(bus.crc16_raw), 64'hFF00);
    chk("data0_is_data",    64'(bus.pkt_is_data), 64'(1));

    // ACK 0xD2 LSB-first with eop on the 8th bit.
    tx_q.delete();
    push_lsb_first(8'hD2);
    send_pkt("ack", 1, 0);
    chk("ack_pid_const",  64'(bus.pid_raw),   64'h004B);
    chk("ack_data_hold",  64'(bus.data_raw),  64'h8000_0000_0000_0000);
    chk("ack_crc_hold",   64'(bus.crc16_raw), 64'hFF00);
    chk("ack_is_data",    64'(bus.pkt_is_data), 64'(0));
    chk("ack_pid_err",    64'(bus.pid_err),   64'(0));

    // 24-bit token packet: length error.
    tx_q.delete();
    push_random(24);
    send_pkt("token", 0, 1);
    chk("token_busy", 64'(bus.busy), 64'(0));

    // 100 bits: overflow, error at eop.
    tx_q.delete();
    push_random(100);
    send_pkt("overflow", 0, 0);

    // Exactly one bit too many, eop coincident.
    tx_q.delete();
    push_random(89);
    send_pkt("len89", 1, 0);

    // Zero-length packet.
    tx_q.delete();
    send_pkt("len0", 0, 0);

    // PID all ones: pid check fails.
    tx_q.delete();
    push_lsb_first(8'hFF);
    send_pkt("pid_ff", 0, 0);
    chk("pid_ff_err_const", 64'(bus.pid_err), 64'(1));
    chk("pid_ff_pid_const", 64'(bus.pid_raw), 64'h00FF);

    // sop at bit 40, then a full valid packet.
    tx_q.delete();
    push_random(40);
    send_pkt("abort40", 2, 0);
    tx_q.delete();
    push_random(8 + DB + 16);
    send_pkt("restart", 0, 1);

    // sop and eop together mid-packet: sop wins, collection restarts.
    tx_q.delete();
    push_random(10);
    send_pkt("sop_eop_pre", 2, 0);
    drive("sop_eop", 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++)
      drive("sop_eop_bit", 1'b0, (i == 7), 1'b1, bit'($urandom_range(0, 1)));
    drive("sop_eop_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Stray bits and eop while idle are ignored.
    drive("idle_junk", 1'b0, 1'b1, 1'b1, 1'b1);
    drive("idle_junk", 1'b0, 1'b0, 1'b1, 1'b0);

    // rst at bit 40: everything clears, no error pulse.
    tx_q.delete();
    push_random(40);
    send_pkt("rst40", 2, 0);
    do_reset("rst40_reset");
    drive("rst40_after", 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized mix of packet kinds.
    for (int p = 0; p < 40; p++) begin
      int kind;
      int len;
      kind = int'($urandom_range(0, 4));
      case (kind)
        0: len = 8;
        1, 2: len = 8 + DB + 16;
        3: begin
          len = int'($urandom_range(1, 8 + DB + 15));
          if (len == 8) len = 9;
        end
        default: len = int'($urandom_range(8 + DB + 17, 120));
      endcase
      tx_q.delete();
      push_random(len);
      send_pkt("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        drive("rand_idle", 1'b0, bit'($urandom_range(0, 1)),
              bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/usb_rx_packet_collector.md
Name: usb_rx_packet_collector

Overview:
- Serial-to-parallel packet collector in the USB receive path, directly upstream of the field bit-order correction stage.
- Takes the decoded, unstuffed bit stream between SOP and EOP and shifts the bits into PID, data and CRC16 registers in raw wire order: the first bit received lands in each field's MSB.
- Flags length and PID-check errors, then presents the parallel fields with a one-cycle ready strobe.

Parameters:
DATA_BITS, 64, payload bits per data packet (8-byte payload); CRC field fixed at 16 bits, PID at 8 bits

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sop  in  1  sync pattern detected; start of packet (one-cycle pulse)
eop  in  1  end of packet detected (one-cycle pulse)
bit_valid  in  1  bit_in carries a decoded, unstuffed bit this cycle
bit_in  in  1  received bit
pid_raw  out  8  collected PID, first-received bit at [7]
data_raw  out  DATA_BITS  collected payload, first-received bit at [DATA_BITS-1]
crc16_raw  out  16  collected CRC, first-received bit at [15]
pkt_ready  out  1  one-cycle pulse: fields valid and complete
pkt_is_data  out  1  1 = data packet (PID+payload+CRC), 0 = PID-only packet; valid with pkt_ready
pid_err  out  1  PID check failed: pid_raw[7:4] != ~pid_raw[3:0]; valid with pkt_ready
rx_error  out  1  one-cycle pulse: length error or aborted packet
busy  out  1  high from the cycle after sop until return to IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): state=IDLE, bit counter=0, all outputs 0. Overrides every other input, including mid-packet; no pkt_ready or rx_error is produced for the abandoned packet.
- States: IDLE, PID, DATA, CRC, OVERFLOW.
  - IDLE: on sop -> PID, clear the counter and shift registers.
  - PID: on each bit_valid, pid_sr <= {pid_sr[6:0], bit_in}. After the 8th bit -> DATA.
  - DATA: shift into data_sr the same way. After DATA_BITS bits -> CRC.
  - CRC: shift into crc_sr. After 16 bits -> OVERFLOW-armed: any further bit_valid before eop -> OVERFLOW.
  - OVERFLOW: ignore bits; on eop pulse rx_error, -> IDLE.
- Bit counter: 7 bits, counts total bits since sop and saturates at 127.
- eop evaluation; a bit_valid coincident with eop is shifted in first, then eop is judged on the updated count:
  - count==8: PID-only packet (handshake). pkt_ready=1, pkt_is_data=0, data_raw and crc16_raw keep their previous values.
  - count==8+DATA_BITS+16: data packet. pkt_ready=1, pkt_is_data=1.
  - any other count, including 0: rx_error=1, pkt_ready=0, output registers unchanged.
  - In all cases -> IDLE.
- Latency: pkt_ready/rx_error assert in the cycle after the clk edge that samples eop. pid_raw, data_raw and crc16_raw update at that same edge and hold until the next pkt_ready.
- pid_err is registered with pkt_ready and holds its value until the next pkt_ready.
- sop while not IDLE: the current packet aborts, rx_error pulses, and collection restarts in PID at the same edge.
- bit_valid or eop while IDLE: ignored.
- sop and eop in the same cycle: sop wins (abort/restart rule), eop ignored.
- busy = (state != IDLE).

Test Plan:
- DATA0 PID 0xC3 sent LSB-first (bits 1,1,0,0,0,0,1,1), 64 payload bits with only the first = 1, 16 CRC bits with the first 8 = 1, then eop -> next cycle: pkt_ready=1, pkt_is_data=1, pid_raw=0xC3, data_raw=64'h8000_0000_0000_0000, crc16_raw=0xFF00, pid_err=0, rx_error=0.
- ACK 0xD2 sent LSB-first, eop coincident with the 8th bit_valid -> pkt_ready=1, pkt_is_data=0, pid_raw=0x4B, pid_err=0, data_raw and crc16_raw unchanged from the previous test.
- 24-bit token packet (8+11+5 bits), then eop -> rx_error pulses one cycle, pkt_ready stays 0, outputs unchanged, busy=0 the next cycle.
- 100 bits after sop -> OVERFLOW; eop -> rx_error=1, no pkt_ready.
- PID bits 1,1,1,1,1,1,1,1 + eop -> pkt_ready=1, pid_raw=0xFF, pid_err=1.
- Mid-payload disturbances:
  - sop at bit 40 -> rx_error pulse, then a full valid packet -> correct pkt_ready.
  - rst at bit 40 -> all outputs 0, busy=0, no rx_error.
